// File: rtl/cr_rst_seq.sv
// cr_rst_seq: multi-channel reset synchroniser and staggered release sequencer
//
// Optional feature macro: CR_RST_SEQ_SOFT_EN
//   defined   -> soft_rst_req port and per-channel minimum-hold logic are built
//   undefined -> no soft_rst_req port; channels stay released in DONE until reset
//
// Ports:
//   clk           single clock, rising edge
//   async_rst     asynchronous active-high reset, release synchronised internally
//   bypass_reset  test bypass enable (qualified by test_rst_n)
//   test_rst_n    test-mode reset qualifier
//   soft_rst_req  per-channel level soft reset request (CR_RST_SEQ_SOFT_EN only)
//   rst_n         active-low channel resets, bit i = channel i
//   seq_done      high once the power-on sequence has released every channel
module cr_rst_seq #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER     = 16,
    parameter int HOLD_MIN    = 8
) (
    input  logic            clk,
    input  logic            async_rst,
    input  logic            bypass_reset,
    input  logic            test_rst_n,
`ifdef CR_RST_SEQ_SOFT_EN
    input  logic [N_CH-1:0] soft_rst_req,
`endif
    output logic [N_CH-1:0] rst_n,
    output logic            seq_done
);
    localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_END = IW'(N_CH - 1);
    typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;
    logic                   byp;
    logic                   int_rst;
    logic                   sync_ok;
    logic                   stag_end;
    logic                   last_ch;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          ch_idx_q, ch_idx_d;
    logic [N_CH-1:0]        ch_rel_q, ch_rel_d;
    logic                   seq_done_q, seq_done_d;
`ifdef CR_RST_SEQ_SOFT_EN
    localparam int HW = $clog2(HOLD_MIN + 1);
    localparam logic [HW-1:0] HMAX  = HW'(HOLD_MIN);
    localparam logic [HW-1:0] HMAX1 = HW'(HOLD_MIN - 1);
    logic [N_CH-1:0][HW-1:0] hold_q, hold_d;
`endif
    assign byp      = bypass_reset & test_rst_n;
    assign int_rst  = async_rst & ~byp;
    assign sync_ok  = sync_q[SYNC_STAGES-1];
    assign stag_end = cnt_q == CNT_END;
    assign last_ch  = ch_idx_q == IDX_END;
    // Bypass forces every channel out of reset combinationally; test mode only.
    assign rst_n    = {N_CH{byp}} | ch_rel_q;
    assign seq_done = seq_done_q;
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_idx_d   = ch_idx_q;
        ch_rel_d   = ch_rel_q;
        seq_done_d = seq_done_q;
`ifdef CR_RST_SEQ_SOFT_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            HOLD: begin
                state_d  = sync_ok ? RELEASE : HOLD;
                cnt_d    = '0;
                ch_idx_d = '0;
            end
            RELEASE: begin
                cnt_d = stag_end ? '0 : cnt_q + CW'(1);
                if (stag_end) begin
                    ch_rel_d[ch_idx_q] = 1'b1;
                    ch_idx_d           = last_ch ? ch_idx_q : ch_idx_q + IW'(1);
                    state_d            = last_ch ? DONE : RELEASE;
                    seq_done_d         = last_ch;
                end
            end
            DONE: begin
`ifdef CR_RST_SEQ_SOFT_EN
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_rel_q[i]) begin
                        ch_rel_d[i] = ~soft_rst_req[i];
                        hold_d[i]   = soft_rst_req[i] ? '0 : hold_q[i];
                    end else begin
                        // A live request caps the count one short of HOLD_MIN, so release
                        // needs a full request-free cycle: low time = max(HOLD_MIN, req) + 1.
                        hold_d[i]   = soft_rst_req[i] ? ((hold_q[i] >= HMAX1) ? HMAX1 : hold_q[i] + HW'(1))
                                                      : ((hold_q[i] == HMAX) ? HMAX : hold_q[i] + HW'(1));
                        ch_rel_d[i] = (hold_q[i] == HMAX) & ~soft_rst_req[i];
                    end
                end
`endif
            end
            default: state_d = HOLD;
        endcase
        // Bypass keeps all state at its reset value so the sequence reruns when it drops.
        if (byp) begin
            sync_d     = '0;
            state_d    = HOLD;
            cnt_d      = '0;
            ch_idx_d   = '0;
            ch_rel_d   = '0;
            seq_done_d = 1'b0;
`ifdef CR_RST_SEQ_SOFT_EN
            hold_d     = '0;
`endif
        end
    end
    always_ff @(posedge clk or posedge int_rst) begin
        if (int_rst) begin
            sync_q     <= '0;
            state_q    <= HOLD;
            cnt_q      <= '0;
            ch_idx_q   <= '0;
            ch_rel_q   <= '0;
            seq_done_q <= 1'b0;
`ifdef CR_RST_SEQ_SOFT_EN
            hold_q     <= '0;
`endif
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_idx_q   <= ch_idx_d;
            ch_rel_q   <= ch_rel_d;
            seq_done_q <= seq_done_d;
`ifdef CR_RST_SEQ_SOFT_EN
            hold_q     <= hold_d;
`endif
        end
    end
endmodule

// File: tb/tb_cr_rst_seq.sv
// tb_cr_rst_seq: scoreboard bench for cr_rst_seq (default parameters)
module tb_cr_rst_seq;
    logic       clk = 1'b0;
    logic       async_rst = 1'b1;
    logic       bypass_reset = 1'b0;
    logic       test_rst_n = 1'b1;
    logic [3:0] rst_n;
    logic       seq_done;
`ifdef CR_RST_SEQ_SOFT_EN
    logic [3:0] soft_rst_req = '0;
`endif
    typedef struct {
        int         cyc;
        logic [4:0] val;
    } ev_t;
    ev_t        sb[$];
    ev_t        e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         base = 0;
    logic       mon_en = 1'b0;
    logic [4:0] prev;
    logic [4:0] cur;

    cr_rst_seq #(.N_CH(4), .SYNC_STAGES(2), .STAGGER(16), .HOLD_MIN(8)) dut (
        .clk(clk),
        .async_rst(async_rst),
        .bypass_reset(bypass_reset),
        .test_rst_n(test_rst_n),
`ifdef CR_RST_SEQ_SOFT_EN
        .soft_rst_req(soft_rst_req),
`endif
        .rst_n(rst_n),
        .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    // Every change of {seq_done, rst_n} must match the next expected event, value and cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            cur = {seq_done, rst_n};
            if (cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d got %b, was %b", cyc - base, cur, prev);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.val || cyc - base != e.cyc) begin
                        errors++;
                        $display("FAIL sequence_event: got %b at cycle %0d, expected %b at cycle %0d", cur, cyc - base, e.val, e.cyc);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic push(input int c, input logic [4:0] v);
        ev_t x;
        x.cyc = c;
        x.val = v;
        sb.push_back(x);
    endtask

    task automatic arm();
        prev   = {seq_done, rst_n};
        base   = cyc;
        mon_en = 1'b1;
    endtask

    // Release 2 sync edges + 1 entry edge, then one channel every 16 cycles.
    task automatic push_seq();
        push(19, 5'b0_0001);
        push(35, 5'b0_0011);
        push(51, 5'b0_0111);
        push(67, 5'b1_1111);
    endtask

    task automatic wait_drain(input string name, input int n);
        repeat (n) @(posedge clk);
        #2;
        mon_en = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d events pending, got %b expected %b", name, sb.size(), {seq_done, rst_n}, sb[0].val);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rst_n: got %b expected 0000", rst_n);
        end
        checks++;
        if (seq_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_seq_done: got %b expected 0", seq_done);
        end
    endtask

    task automatic test_power_on();
        @(negedge clk);
        async_rst = 1'b0;
        push_seq();
        arm();
        wait_drain("power_on", 80);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        async_rst = 1'b1;
        @(negedge clk);
        async_rst = 1'b0;
        push(19, 5'b0_0001);
        push(35, 5'b0_0011);
        arm();
        wait_drain("mid_first", 43);
        async_rst = 1'b1;
        #1;
        checks++;
        if ({seq_done, rst_n} !== 5'b0_0000) begin
            errors++;
            $display("FAIL mid_async_drop: got %b expected 00000", {seq_done, rst_n});
        end
        @(negedge clk);
        async_rst = 1'b0;
        push_seq();
        arm();
        wait_drain("mid_restart", 80);
    endtask

`ifdef CR_RST_SEQ_SOFT_EN
    task automatic test_soft_ignored();
        @(negedge clk);
        async_rst = 1'b1;
        @(negedge clk);
        async_rst = 1'b0;
        soft_rst_req = 4'b1111;
        push_seq();
        arm();
        repeat (67) @(posedge clk);
        #2;
        soft_rst_req = 4'b0000;
        wait_drain("soft_ignored", 10);
    endtask

    task automatic test_soft_pulse();
        @(negedge clk);
        soft_rst_req[2] = 1'b1;
        push(1, 5'b1_1011);
        push(10, 5'b1_1111);
        arm();
        @(negedge clk);
        soft_rst_req[2] = 1'b0;
        wait_drain("soft_pulse", 20);
    endtask

    task automatic test_soft_parallel();
        @(negedge clk);
        soft_rst_req = 4'b1010;
        push(1, 5'b1_0101);
        push(10, 5'b1_1101);
        push(22, 5'b1_1111);
        arm();
        @(negedge clk);
        soft_rst_req[3] = 1'b0;
        repeat (19) @(negedge clk);
        soft_rst_req[1] = 1'b0;
        wait_drain("soft_parallel", 10);
    endtask
`else
    task automatic test_done_hold();
        arm();
        repeat (200) @(posedge clk);
        #2;
        mon_en = 1'b0;
        checks++;
        if ({seq_done, rst_n} !== 5'b1_1111) begin
            errors++;
            $display("FAIL done_hold: got %b expected 11111", {seq_done, rst_n});
        end
    endtask
`endif

    task automatic test_bypass();
        @(negedge clk);
        async_rst = 1'b1;
        #1;
        bypass_reset = 1'b1;
        #1;
        checks++;
        if (rst_n !== 4'b1111 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL bypass_on: got %b/%b expected 1111/0", rst_n, seq_done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rst_n !== 4'b1111) begin
            errors++;
            $display("FAIL bypass_hold: got %b expected 1111", rst_n);
        end
        bypass_reset = 1'b0;
        #1;
        checks++;
        if (rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL bypass_off: got %b expected 0000", rst_n);
        end
        @(negedge clk);
        async_rst = 1'b0;
        push_seq();
        arm();
        wait_drain("bypass_rerun", 80);
        @(negedge clk);
        async_rst = 1'b1;
        test_rst_n = 1'b0;
        bypass_reset = 1'b1;
        #1;
        checks++;
        if (rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL bypass_unqualified: got %b expected 0000", rst_n);
        end
        @(negedge clk);
        async_rst = 1'b0;
        push_seq();
        arm();
        wait_drain("unqualified_seq", 80);
        bypass_reset = 1'b0;
        test_rst_n = 1'b1;
        @(negedge clk);
        bypass_reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rst_n !== 4'b1111 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL bypass_done_clear: got %b/%b expected 1111/0", rst_n, seq_done);
        end
        bypass_reset = 1'b0;
        #1;
        checks++;
        if (rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL bypass_done_drop: got %b expected 0000", rst_n);
        end
        push_seq();
        arm();
        wait_drain("bypass_done_rerun", 80);
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_mid_reset();
`ifdef CR_RST_SEQ_SOFT_EN
        test_soft_pulse();
        test_soft_parallel();
        test_soft_ignored();
`else
        test_done_hold();
`endif
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
